// File: rtl/fifo_hw_checker_pkg.sv
// fifo_hw_checker_pkg: check indices, observation bundle and helpers for the FIFO checker
package fifo_hw_checker_pkg;
  localparam int NUM_CHECKS = 8;
  typedef enum logic [2:0] {
    CHK_DATA, CHK_WR_ACK, CHK_OVERFLOW, CHK_UNDERFLOW,
    CHK_FULL, CHK_EMPTY, CHK_AFULL, CHK_AEMPTY
  } chk_idx_e;
  typedef struct packed {
    logic wr_en;
    logic rd_en;
    logic wr_ack;
    logic overflow;
    logic underflow;
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
  } fifo_obs_t;
  function automatic logic [2:0] first_set(input logic [NUM_CHECKS-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--)
      if (v[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/fifo_hw_checker_ref_model.sv
// fifo_ref_model: shadow occupancy counter and RAM predicting the FIFO outputs
module fifo_ref_model #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_W:0] count,
  output logic exp_full,
  output logic exp_empty,
  output logic exp_afull,
  output logic exp_aempty,
  output logic exp_wr_ack,
  output logic exp_overflow,
  output logic exp_underflow,
  output logic exp_rd_valid,
  output logic [DATA_WIDTH-1:0] exp_data_out
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign exp_full = count == (ADDR_W+1)'(DEPTH);
  assign exp_empty = count == '0;
  assign exp_afull = count == (ADDR_W+1)'(DEPTH - 1);
  assign exp_aempty = count == (ADDR_W+1)'(1);
  assign wr_ok = wr_en && !exp_full;
  assign rd_ok = rd_en && !exp_empty;
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      exp_wr_ack <= 1'b0;
      exp_overflow <= 1'b0;
      exp_underflow <= 1'b0;
      exp_rd_valid <= 1'b0;
      exp_data_out <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(wr_ok);
      rd_ptr <= rd_ptr + ADDR_W'(rd_ok);
      count <= count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
      exp_wr_ack <= wr_ok;
      exp_overflow <= wr_en && exp_full;
      exp_underflow <= rd_en && exp_empty;
      exp_rd_valid <= rd_ok;
      if (rd_ok) exp_data_out <= mem[rd_ptr];
    end
  end
endmodule

// File: rtl/fifo_hw_checker.sv
// fifo_hw_checker: passive FIFO checker comparing observed ports against a reference model
module fifo_hw_checker
  import fifo_hw_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int CYC_W = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic chk_en,
  input  logic clr_stats,
  input  logic [DATA_WIDTH-1:0] mon_data_in,
  input  logic mon_wr_en,
  input  logic mon_rd_en,
  input  logic [DATA_WIDTH-1:0] mon_data_out,
  input  logic mon_wr_ack,
  input  logic mon_overflow,
  input  logic mon_underflow,
  input  logic mon_full,
  input  logic mon_empty,
  input  logic mon_almostfull,
  input  logic mon_almostempty,
  output logic err_any,
  output logic [NUM_CHECKS-1:0] err_vec,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] pass_count,
  output logic [2:0] first_err_code,
  output logic [CYC_W-1:0] first_err_cycle,
  output logic first_err_valid,
  output logic [ADDR_W:0] model_count
);
  fifo_obs_t obs;
  logic exp_full, exp_empty, exp_afull, exp_aempty;
  logic exp_wr_ack, exp_overflow, exp_underflow, exp_rd_valid;
  logic [DATA_WIDTH-1:0] exp_data_out;
  logic [NUM_CHECKS-1:0] mis;
  logic [1:0] mask;
  logic [CYC_W-1:0] cyc;
  logic counted;
  assign obs = '{wr_en: mon_wr_en, rd_en: mon_rd_en, wr_ack: mon_wr_ack,
                 overflow: mon_overflow, underflow: mon_underflow, full: mon_full,
                 empty: mon_empty, almostfull: mon_almostfull, almostempty: mon_almostempty};
  fifo_ref_model #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_model (
    .clk(clk), .rst_n(rst_n), .wr_en(obs.wr_en), .rd_en(obs.rd_en), .data_in(mon_data_in),
    .count(model_count), .exp_full(exp_full), .exp_empty(exp_empty), .exp_afull(exp_afull),
    .exp_aempty(exp_aempty), .exp_wr_ack(exp_wr_ack), .exp_overflow(exp_overflow),
    .exp_underflow(exp_underflow), .exp_rd_valid(exp_rd_valid), .exp_data_out(exp_data_out)
  );
  // Data is only meaningful after a read the model accepted
  assign mis = {obs.almostempty != exp_aempty, obs.almostfull != exp_afull,
                obs.empty != exp_empty, obs.full != exp_full,
                obs.underflow != exp_underflow, obs.overflow != exp_overflow,
                obs.wr_ack != exp_wr_ack, exp_rd_valid && (mon_data_out != exp_data_out)};
  assign counted = chk_en && mask == 2'd0;
  assign err_any = |err_vec;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask <= 2'd2;
      cyc <= '0;
      err_vec <= '0;
      err_count <= '0;
      pass_count <= '0;
      first_err_code <= '0;
      first_err_cycle <= '0;
      first_err_valid <= 1'b0;
    end else begin
      cyc <= cyc + 1'b1;
      if (mask != 2'd0) mask <= mask - 2'd1;
      if (clr_stats) begin
        err_vec <= '0;
        err_count <= '0;
        pass_count <= '0;
        first_err_code <= '0;
        first_err_cycle <= '0;
        first_err_valid <= 1'b0;
      end else if (counted && |mis) begin
        err_count <= err_count + CNT_W'(err_count != '1);
        err_vec <= err_vec | mis;
        if (!first_err_valid) begin
          first_err_code <= first_set(mis);
          first_err_cycle <= cyc;
          first_err_valid <= 1'b1;
        end
      end else if (counted) pass_count <= pass_count + CNT_W'(pass_count != '1);
    end
  end
endmodule

// File: tb/tb_fifo_hw_checker.sv
// tb_fifo_hw_checker: directed checks of the FIFO checker against a behavioural FIFO with fault knobs
module tb_fifo_hw_checker;
  logic clk = 0, rst_n = 0, chk_en = 1, clr_stats = 0;
  logic wr_en = 0, rd_en = 0;
  logic [15:0] din = '0;
  logic drop_ovf = 0, corrupt = 0, bad_full = 0;
  logic [15:0] mon_data_out;
  logic mon_wr_ack, mon_overflow, mon_underflow;
  logic mon_full, mon_empty, mon_almostfull, mon_almostempty;
  logic [15:0] fmem [8];
  logic [2:0] fwp, frp;
  logic [3:0] fcnt;
  logic f_wok, f_rok;
  int n_vec = 0, n_bad = 0;
  logic m_err_any, m_fev;
  logic [7:0] m_err_vec;
  logic [15:0] m_err_count, m_pass_count;
  logic [2:0] m_fec;
  logic [31:0] m_fecyc;
  logic [3:0] m_cnt;
  logic s_err_any, s_fev;
  logic [7:0] s_err_vec;
  logic [3:0] s_err_count, s_pass_count;
  logic [2:0] s_fec;
  logic [31:0] s_fecyc;
  logic [3:0] s_cnt;
  always #5 clk = ~clk;
  assign f_wok = wr_en && fcnt != 4'd8;
  assign f_rok = rd_en && fcnt != 4'd0;
  assign mon_full = fcnt == 4'd8;
  assign mon_empty = fcnt == 4'd0;
  assign mon_almostfull = fcnt == 4'd7;
  assign mon_almostempty = fcnt == 4'd1;
  always @(posedge clk) begin
    if (!rst_n) begin
      fwp <= '0;
      frp <= '0;
      fcnt <= '0;
      mon_data_out <= '0;
      mon_wr_ack <= 0;
      mon_overflow <= 0;
      mon_underflow <= 0;
    end else begin
      if (f_wok) begin
        fmem[fwp] <= din;
        fwp <= fwp + 3'd1;
      end
      if (f_rok) begin
        frp <= frp + 3'd1;
        mon_data_out <= corrupt ? 16'h0009 : fmem[frp];
      end
      fcnt <= fcnt + 4'(f_wok) - 4'(f_rok);
      mon_wr_ack <= f_wok;
      mon_overflow <= wr_en && fcnt == 4'd8 && !drop_ovf;
      mon_underflow <= rd_en && fcnt == 4'd0;
    end
  end
  fifo_hw_checker u_dut (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr_stats(clr_stats), .mon_data_in(din),
    .mon_wr_en(wr_en), .mon_rd_en(rd_en), .mon_data_out(mon_data_out), .mon_wr_ack(mon_wr_ack),
    .mon_overflow(mon_overflow), .mon_underflow(mon_underflow), .mon_full(mon_full),
    .mon_empty(mon_empty), .mon_almostfull(mon_almostfull), .mon_almostempty(mon_almostempty),
    .err_any(m_err_any), .err_vec(m_err_vec), .err_count(m_err_count), .pass_count(m_pass_count),
    .first_err_code(m_fec), .first_err_cycle(m_fecyc), .first_err_valid(m_fev), .model_count(m_cnt)
  );
  fifo_hw_checker #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr_stats(clr_stats), .mon_data_in(din),
    .mon_wr_en(wr_en), .mon_rd_en(rd_en), .mon_data_out(mon_data_out), .mon_wr_ack(mon_wr_ack),
    .mon_overflow(mon_overflow), .mon_underflow(mon_underflow), .mon_full(mon_full ^ bad_full),
    .mon_empty(mon_empty), .mon_almostfull(mon_almostfull), .mon_almostempty(mon_almostempty),
    .err_any(s_err_any), .err_vec(s_err_vec), .err_count(s_err_count), .pass_count(s_pass_count),
    .first_err_code(s_fec), .first_err_cycle(s_fecyc), .first_err_valid(s_fev), .model_count(s_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic w, input logic r, input logic [15:0] d);
    wr_en = w;
    rd_en = r;
    din = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(0, 0, 0);
    step(0, 0, 0);
    check("rst_err_any", 32'(m_err_any), 0);
    check("rst_pass", 32'(m_pass_count), 0);
    check("rst_count", 32'(m_cnt), 0);
    check("rst_fev", 32'(m_fev), 0);
    rst_n = 1;
    for (int k = 1; k <= 8; k++) step(1, 0, 16'(k));
    check("fill_count", 32'(m_cnt), 8);
    check("fill_full", 32'(mon_full), 1);
    check("fill_pass", 32'(m_pass_count), 6);
    check("fill_err_any", 32'(m_err_any), 0);
    drop_ovf = 1;
    step(1, 0, 16'h0009);
    step(0, 0, 0);
    drop_ovf = 0;
    check("ovf_vec", 32'(m_err_vec), 32'h04);
    check("ovf_code", 32'(m_fec), 2);
    check("ovf_cycle", m_fecyc, 9);
    check("ovf_errcnt", 32'(m_err_count), 1);
    check("ovf_pass", 32'(m_pass_count), 7);
    clr_stats = 1;
    step(0, 0, 0);
    clr_stats = 0;
    check("clr_vec", 32'(m_err_vec), 0);
    check("clr_fev", 32'(m_fev), 0);
    for (int k = 1; k <= 8; k++) begin
      corrupt = k == 3;
      step(0, 1, 0);
      check($sformatf("rd%0d_data", k), 32'(mon_data_out), k == 3 ? 9 : k);
    end
    corrupt = 0;
    check("rd_count", 32'(m_cnt), 0);
    step(0, 0, 0);
    check("rd_vec", 32'(m_err_vec), 32'h01);
    check("rd_errcnt", 32'(m_err_count), 1);
    check("rd_code", 32'(m_fec), 0);
    check("rd_cycle", m_fecyc, 14);
    check("rd_pass", 32'(m_pass_count), 8);
    clr_stats = 1;
    step(0, 0, 0);
    clr_stats = 0;
    step(1, 1, 16'h000A);
    check("sim0_count", 32'(m_cnt), 1);
    step(0, 0, 0);
    for (int k = 0; k < 7; k++) step(1, 0, 16'(16'h000B + k));
    check("sim_full_count", 32'(m_cnt), 8);
    step(1, 1, 16'h0012);
    check("sim8_count", 32'(m_cnt), 7);
    step(0, 0, 0);
    check("sim_pass", 32'(m_pass_count), 11);
    check("sim_err_any", 32'(m_err_any), 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check("pre_rst_count", 32'(m_cnt), 5);
    rst_n = 0;
    step(0, 0, 0);
    rst_n = 1;
    check("mrst_count", 32'(m_cnt), 0);
    check("mrst_pass", 32'(m_pass_count), 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("mask_pass", 32'(m_pass_count), 0);
    step(0, 1, 0);
    step(0, 0, 0);
    check("udf_pass", 32'(m_pass_count), 2);
    check("udf_errcnt", 32'(m_err_count), 0);
    bad_full = 1;
    for (int k = 0; k < 20; k++) step(0, 0, 0);
    check("sat_errcnt", 32'(s_err_count), 15);
    check("sat_vec", 32'(s_err_vec), 32'h10);
    check("sat_code", 32'(s_fec), 4);
    check("sat_main_ok", 32'(m_err_any), 0);
    clr_stats = 1;
    step(0, 0, 0);
    clr_stats = 0;
    check("clrwin_errcnt", 32'(s_err_count), 0);
    check("clrwin_vec", 32'(s_err_vec), 0);
    check("clrwin_pass", 32'(s_pass_count), 0);
    check("clrwin_fev", 32'(s_fev), 0);
    check("clrwin_any", 32'(s_err_any), 0);
    bad_full = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
